event_flash_driver: RTL and testbench



---
 rtl/event_flash_driver.sv | 93 +++++++++
 tb/tb_event_flash_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/event_flash_driver.sv
// Turns one-cycle event pulses into fixed-length flashes on an LED or buzzer pin.
// Events that arrive during a flash are queued in a saturating counter and replayed one gap apart.
module event_flash_driver #(
    parameter int TICK_DIV  = 250000,
    parameter int ON_TICKS  = 40,
    parameter int GAP_TICKS = 40,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              ovf
);
    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int MAX_T  = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TCNT_W = $clog2(MAX_T + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST = TCNT_W'(GAP_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t             state;
    logic [PRE_W-1:0]   pre;
    logic [TCNT_W-1:0]  tcnt;
    logic               tick, last_on, last_gap, start, pend_nz;

    always_comb begin
        pend_nz  = (pend_cnt != '0);
        tick     = (pre == PRE_LAST);
        last_on  = (state == ON)  && tick && (tcnt == ON_LAST);
        last_gap = (state == GAP) && tick && (tcnt == GAP_LAST);
        start    = ((state == IDLE) && (pend_nz || ev_in)) || (last_gap && pend_nz);
    end

    assign busy = (state != IDLE) || pend_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            led_out  <= 1'b0;
            pend_cnt <= '0;
            ovf      <= 1'b0;
            pre      <= '0;
            tcnt     <= '0;
        end else begin
            ovf <= 1'b0;

            // A start from an empty queue consumes ev_in directly, so nothing is queued.
            if (start && !pend_nz) begin
                pend_cnt <= pend_cnt;
            end else if (ev_in && !start) begin
                if (pend_cnt == PEND_MAX) ovf <= 1'b1;
                else                      pend_cnt <= pend_cnt + 1'b1;
            end else if (start && !ev_in) begin
                pend_cnt <= pend_cnt - 1'b1;
            end

            // Prescaler and tick counter restart on every state entry so each phase is exact.
            if (start || last_on || last_gap || state == IDLE) begin
                pre  <= '0;
                tcnt <= '0;
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) tcnt <= tcnt + 1'b1;
            end

            case (state)
                IDLE: if (start) begin
                    state   <= ON;
                    led_out <= 1'b1;
                end
                ON: if (last_on) begin
                    state   <= GAP;
                    led_out <= 1'b0;
                end
                GAP: if (last_gap) begin
                    state   <= start ? ON : IDLE;
                    led_out <= start;
                end
                default: begin
                    state   <= IDLE;
                    led_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_event_flash_driver.sv
// Directed checks of flash timing, queueing, overflow and asynchronous reset for event_flash_driver.
// Cycle n is the interval after the n-th rising edge following reset release.
module tb_event_flash_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ev_in = 1'b0;
    logic       led_out, busy, ovf;
    logic [1:0] pend_cnt;
    int         n_checks = 0;
    int         n_fail = 0;

    event_flash_driver #(.TICK_DIV(4), .ON_TICKS(3), .GAP_TICKS(2), .PEND_W(2)) dut (
        .clk(clk), .rst(rst), .ev_in(ev_in),
        .led_out(led_out), .busy(busy), .pend_cnt(pend_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1 time unit into cycle 0 with reset released.
    task automatic apply_reset();
        rst = 1'b1;
        ev_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst = 1'b1;
        #2;
        n_checks++;
        if ({led_out, busy, pend_cnt, ovf} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_held got led/busy/pend/ovf=%b exp %b", {led_out, busy, pend_cnt, ovf}, 5'b0);
        end
        apply_reset();
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            exp = 5'b0;
            n_checks++;
            if ({led_out, busy, pend_cnt, ovf} !== exp) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got %b exp %b", c, {led_out, busy, pend_cnt, ovf}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        logic [4:0] exp;
        apply_reset();
        for (int c = 0; c <= 35; c++) begin
            ev_in = (c == 10);
            @(negedge clk);
            exp = {(c >= 11 && c <= 22), (c >= 11 && c <= 30), 2'd0, 1'b0};
            n_checks++;
            if ({led_out, busy, pend_cnt, ovf} !== exp) begin
                n_fail++;
                $display("FAIL single c=%0d got led/busy/pend/ovf=%b exp %b", c, {led_out, busy, pend_cnt, ovf}, exp);
            end
            @(posedge clk); #1;
        end
        ev_in = 1'b0;
    endtask

    task automatic test_burst();
        logic [4:0] exp;
        logic [1:0] ep;
        apply_reset();
        for (int c = 0; c <= 75; c++) begin
            ev_in = (c >= 10 && c <= 12);
            @(negedge clk);
            ep  = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c < 31) ? 2'd2 : (c < 51) ? 2'd1 : 2'd0;
            exp = {((c >= 11 && c <= 22) || (c >= 31 && c <= 42) || (c >= 51 && c <= 62)),
                   (c >= 11 && c <= 70), ep, 1'b0};
            n_checks++;
            if ({led_out, busy, pend_cnt, ovf} !== exp) begin
                n_fail++;
                $display("FAIL burst c=%0d got led/busy/pend/ovf=%b exp %b", c, {led_out, busy, pend_cnt, ovf}, exp);
            end
            @(posedge clk); #1;
        end
        ev_in = 1'b0;
    endtask

    task automatic test_overflow();
        logic [4:0] exp;
        logic [1:0] ep;
        logic       prev_led = 1'b0;
        int         flashes = 0;
        apply_reset();
        for (int c = 0; c <= 95; c++) begin
            ev_in = (c == 10) || (c >= 13 && c <= 16);
            @(negedge clk);
            ep  = (c < 14) ? 2'd0 : (c == 14) ? 2'd1 : (c == 15) ? 2'd2 : (c < 31) ? 2'd3 :
                  (c < 51) ? 2'd2 : (c < 71) ? 2'd1 : 2'd0;
            exp = {((c >= 11 && c <= 22) || (c >= 31 && c <= 42) || (c >= 51 && c <= 62) || (c >= 71 && c <= 82)),
                   (c >= 11 && c <= 90), ep, (c == 17)};
            n_checks++;
            if ({led_out, busy, pend_cnt, ovf} !== exp) begin
                n_fail++;
                $display("FAIL overflow c=%0d got led/busy/pend/ovf=%b exp %b", c, {led_out, busy, pend_cnt, ovf}, exp);
            end
            if (led_out === 1'b1 && prev_led === 1'b0) flashes++;
            prev_led = led_out;
            @(posedge clk); #1;
        end
        ev_in = 1'b0;
        n_checks++;
        if (flashes != 4) begin
            n_fail++;
            $display("FAIL overflow_flash_count got %0d exp 4", flashes);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        logic [1:0] ep;
        apply_reset();
        for (int c = 0; c <= 75; c++) begin
            // c==30 is the last GAP cycle of the first flash, where inc and dec coincide.
            ev_in = (c == 10) || (c == 11) || (c == 30);
            @(negedge clk);
            ep  = (c < 12) ? 2'd0 : (c < 51) ? 2'd1 : 2'd0;
            exp = {((c >= 11 && c <= 22) || (c >= 31 && c <= 42) || (c >= 51 && c <= 62)),
                   (c >= 11 && c <= 70), ep, 1'b0};
            n_checks++;
            if ({led_out, busy, pend_cnt, ovf} !== exp) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d got led/busy/pend/ovf=%b exp %b", c, {led_out, busy, pend_cnt, ovf}, exp);
            end
            @(posedge clk); #1;
        end
        ev_in = 1'b0;
    endtask

    task automatic test_reset_mid_flash();
        logic [4:0] exp;
        apply_reset();
        for (int c = 0; c <= 14; c++) begin
            ev_in = (c >= 10 && c <= 12);
            @(negedge clk);
            @(posedge clk); #1;
        end
        ev_in = 1'b0;
        // Now 1 unit into cycle 15: mid-flash with two events queued.
        n_checks++;
        if ({led_out, busy, pend_cnt} !== 4'b1110) begin
            n_fail++;
            $display("FAIL mid_flash_pre got led/busy/pend=%b exp %b", {led_out, busy, pend_cnt}, 4'b1110);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({led_out, busy, pend_cnt, ovf} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_flash_async got led/busy/pend/ovf=%b exp %b", {led_out, busy, pend_cnt, ovf}, 5'b0);
        end
        apply_reset();
        for (int c = 0; c <= 42; c++) begin
            ev_in = (c == 20);
            @(negedge clk);
            exp = {(c >= 21 && c <= 32), (c >= 21 && c <= 40), 2'd0, 1'b0};
            n_checks++;
            if ({led_out, busy, pend_cnt, ovf} !== exp) begin
                n_fail++;
                $display("FAIL after_reset c=%0d got led/busy/pend/ovf=%b exp %b", c, {led_out, busy, pend_cnt, ovf}, exp);
            end
            @(posedge clk); #1;
        end
        ev_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_back_to_back();
        test_reset_mid_flash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
